// File: rtl/router_pkg.sv
// Shared definitions for the packet router destination synchroniser.
//   ROUTER_NUM_PORTS : default number of output FIFOs / ports
//   ROUTER_ADDR_W    : default width of the destination address field
//   ROUTER_TIMEOUT   : default stalled-read cycles before a port flush
//   port_mask_t      : one bit per output port at the default port count
package router_pkg;

  localparam int ROUTER_NUM_PORTS = 3;
  localparam int ROUTER_ADDR_W    = 2;
  localparam int ROUTER_TIMEOUT   = 30;

  typedef logic [ROUTER_NUM_PORTS-1:0] port_mask_t;

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-port read-timeout watchdog.
// Counts consecutive cycles in which the port holds valid data that nobody
// reads. After TIMEOUT such clock edges it raises a one-cycle soft_reset
// pulse so the output FIFO can be flushed.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  synchronous reset, active-low
//   vld        in  port has data waiting (FIFO not empty)
//   rd_en      in  downstream is reading the port this cycle
//   soft_reset out one-cycle flush pulse (registered)
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // The pulse cycle itself is never counted, so a persistent stall produces
  // pulses spaced TIMEOUT+1 cycles apart and the counter never passes
  // TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (vld && !rd_en) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Destination synchroniser between the router FSM and NUM_PORTS output FIFOs.
// Latches the header destination address, steers the FIFO write enable to the
// addressed port, returns that port's full flag, drives per-port valid-out and
// per-port read-timeout flush pulses. Addresses beyond the last port are
// flagged and their packets are silently dropped.
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous reset, active-low
//   din         in  destination address from the header byte
//   detect_addr in  header valid, load din into the address register
//   wr_en_reg   in  router FSM write request
//   full        in  per-FIFO full flags
//   empty       in  per-FIFO empty flags
//   rd_en       in  per-port read enables from downstream
//   wr_en       out one-hot FIFO write enable (comb)
//   fifo_full   out full flag of the addressed FIFO (comb)
//   vld_out     out per-port data valid, ~empty (comb)
//   soft_reset  out per-port one-cycle FIFO flush pulse (reg)
//   addr_err    out latched address is not a real port (reg)
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int ADDR_W    = ROUTER_ADDR_W,
  parameter int TIMEOUT   = ROUTER_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    din,
  input  logic                 detect_addr,
  input  logic                 wr_en_reg,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] rd_en,
  output logic [NUM_PORTS-1:0] wr_en,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  // One extra bit so NUM_PORTS == 2**ADDR_W still fits in the comparison.
  localparam logic [ADDR_W:0] NUM_PORTS_L = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0] addr_q;

  // Address register stage: a new address steers from the next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (detect_addr) begin
      addr_q   <= din;
      addr_err <= ({1'b0, din} >= NUM_PORTS_L);
    end
  end

  // Steering: a bad address matches no port, so writes are dropped and the
  // router never sees a full flag that could stall it.
  always_comb begin
    wr_en     = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!addr_err && (addr_q == ADDR_W'(i))) begin
        wr_en[i]  = wr_en_reg;
        fifo_full = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    router_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
    ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .vld       (vld_out[i]),
      .rd_en     (rd_en[i]),
      .soft_reset(soft_reset[i])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
module tb_router_sync_n;
  import router_pkg::*;

  localparam int NP = 3;
  localparam int AW = 2;
  localparam int TO = 30;

  logic          clk;
  logic          rst;
  logic [AW-1:0] din;
  logic          detect_addr;
  logic          wr_en_reg;
  logic [NP-1:0] full;
  logic [NP-1:0] empty;
  logic [NP-1:0] rd_en;
  logic [NP-1:0] wr_en;
  logic          fifo_full;
  logic [NP-1:0] vld_out;
  logic [NP-1:0] soft_reset;
  logic          addr_err;

  router_sync_n #(
    .NUM_PORTS(NP),
    .ADDR_W   (AW),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .detect_addr(detect_addr),
    .wr_en_reg  (wr_en_reg),
    .full       (full),
    .empty      (empty),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .fifo_full  (fifo_full),
    .vld_out    (vld_out),
    .soft_reset (soft_reset),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [AW-1:0] din;
    logic          det;
    logic          wer;
    logic [NP-1:0] full;
    logic [NP-1:0] empty;
    logic [NP-1:0] rd;
    logic [NP-1:0] e_wr;
    logic          e_ff;
    logic [NP-1:0] e_sr;
    logic          e_err;
    string         name;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic [AW-1:0] d, logic det, logic wer,
                              logic [NP-1:0] f, logic [NP-1:0] em, logic [NP-1:0] rd,
                              logic [NP-1:0] ewr, logic eff, logic [NP-1:0] esr,
                              logic eerr, string nm);
    vec_t v;
    v.rst = r; v.din = d; v.det = det; v.wer = wer; v.full = f; v.empty = em;
    v.rd = rd; v.e_wr = ewr; v.e_ff = eff; v.e_sr = esr; v.e_err = eerr; v.name = nm;
    return v;
  endfunction

  // Drive one cycle's inputs just after the rising edge, queue the expected
  // outputs, then compare at the falling edge.
  task automatic cycle(input vec_t v);
    vec_t e;
    rst = v.rst; din = v.din; detect_addr = v.det; wr_en_reg = v.wer;
    full = v.full; empty = v.empty; rd_en = v.rd;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wr_en !== e.e_wr || fifo_full !== e.e_ff || vld_out !== ~e.empty ||
        soft_reset !== e.e_sr || addr_err !== e.e_err) begin
      errors++;
      $display("FAIL %s: got wr_en=%b fifo_full=%b vld_out=%b soft_reset=%b addr_err=%b, want wr_en=%b fifo_full=%b vld_out=%b soft_reset=%b addr_err=%b",
               e.name, wr_en, fifo_full, vld_out, soft_reset, addr_err,
               e.e_wr, e.e_ff, ~e.empty, e.e_sr, e.e_err);
    end
    @(posedge clk);
    #1;
  endtask

  // Timeout cycle: no writes, no full flags, address stays valid.
  task automatic stall(input logic r, input logic [NP-1:0] em, input logic [NP-1:0] rd,
                       input logic [NP-1:0] esr, input string nm);
    cycle(mk(r, '0, 1'b0, 1'b0, '0, em, rd, '0, 1'b0, esr, 1'b0, nm));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; din = '0; detect_addr = 1'b0; wr_en_reg = 1'b0;
    full = '0; empty = '1; rd_en = '0;
    @(posedge clk); @(posedge clk); #1;

    //          rst  din   det  wer  full    empty   rd      e_wr    e_ff e_sr    e_err
    tbl[0]  = mk(0, 2'd0, 0, 1, 3'b001, 3'b111, 3'b000, 3'b001, 1, 3'b000, 0, "reset_state");
    tbl[1]  = mk(1, 2'd2, 1, 0, 3'b100, 3'b111, 3'b000, 3'b000, 0, 3'b000, 0, "load_addr2");
    tbl[2]  = mk(1, 2'd0, 0, 1, 3'b100, 3'b111, 3'b000, 3'b100, 1, 3'b000, 0, "steer2");
    tbl[3]  = mk(1, 2'd0, 0, 0, 3'b100, 3'b111, 3'b000, 3'b000, 1, 3'b000, 0, "steer2_idle");
    tbl[4]  = mk(1, 2'd0, 0, 1, 3'b011, 3'b111, 3'b000, 3'b100, 0, 3'b000, 0, "steer2_others_full");
    tbl[5]  = mk(1, 2'd0, 1, 1, 3'b000, 3'b111, 3'b000, 3'b100, 0, 3'b000, 0, "same_edge_old_addr");
    tbl[6]  = mk(1, 2'd0, 0, 1, 3'b001, 3'b111, 3'b000, 3'b001, 1, 3'b000, 0, "same_edge_new_addr");
    tbl[7]  = mk(1, 2'd3, 1, 0, 3'b111, 3'b111, 3'b000, 3'b000, 1, 3'b000, 0, "load_bad_addr");
    tbl[8]  = mk(1, 2'd0, 0, 1, 3'b111, 3'b111, 3'b000, 3'b000, 0, 3'b000, 1, "bad_addr_dropped");
    tbl[9]  = mk(1, 2'd1, 1, 1, 3'b111, 3'b111, 3'b000, 3'b000, 0, 3'b000, 1, "load_addr1");
    tbl[10] = mk(1, 2'd0, 0, 1, 3'b010, 3'b111, 3'b000, 3'b010, 1, 3'b000, 0, "steer1");
    tbl[11] = mk(1, 2'd0, 0, 0, 3'b000, 3'b010, 3'b111, 3'b000, 0, 3'b000, 0, "vld_map");
    tbl[12] = mk(0, 2'd0, 0, 1, 3'b001, 3'b111, 3'b000, 3'b010, 0, 3'b000, 0, "reset_edge");
    tbl[13] = mk(1, 2'd0, 0, 1, 3'b001, 3'b111, 3'b000, 3'b001, 1, 3'b000, 0, "post_reset_addr0");

    for (int i = 0; i < 14; i++) cycle(tbl[i]);

    // Port 1 stalled: pulse after 30th stalled edge, next one 31 cycles later.
    for (int c = 1; c <= 30; c++) stall(1, 3'b101, 3'b000, 3'b000, "to_wait1");
    stall(1, 3'b101, 3'b000, 3'b010, "to_pulse1");
    for (int c = 32; c <= 61; c++) stall(1, 3'b101, 3'b000, 3'b000, "to_wait2");
    stall(1, 3'b101, 3'b000, 3'b010, "to_pulse2");
    stall(1, 3'b111, 3'b000, 3'b000, "to_release");

    // Read at the 29th edge restarts the count from zero.
    for (int c = 1; c <= 28; c++) stall(1, 3'b101, 3'b000, 3'b000, "rd_wait");
    stall(1, 3'b101, 3'b010, 3'b000, "rd_edge29");
    for (int c = 30; c <= 59; c++) stall(1, 3'b101, 3'b000, 3'b000, "rd_restart");
    stall(1, 3'b101, 3'b000, 3'b010, "rd_late_pulse");
    stall(1, 3'b111, 3'b000, 3'b000, "rd_release");

    // Reset in the middle of a stall on port 0, with address 2 loaded.
    cycle(mk(1, 2'd2, 1, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 3'b000, 0, "rst_load2"));
    for (int c = 1; c <= 20; c++) stall(1, 3'b110, 3'b000, 3'b000, "rst_stall_pre");
    stall(0, 3'b110, 3'b000, 3'b000, "rst_mid_stall");
    cycle(mk(1, 2'd0, 0, 1, 3'b001, 3'b110, 3'b000, 3'b001, 1, 3'b000, 0, "rst_addr0"));
    for (int c = 23; c <= 51; c++) stall(1, 3'b110, 3'b000, 3'b000, "rst_stall_post");
    stall(1, 3'b110, 3'b000, 3'b001, "rst_pulse_fresh");
    stall(1, 3'b111, 3'b000, 3'b000, "rst_release");

    // Ports 0 and 2 stalled together; address load during the pulse.
    for (int c = 1; c <= 30; c++) stall(1, 3'b010, 3'b000, 3'b000, "cc_wait");
    cycle(mk(1, 2'd1, 1, 0, 3'b000, 3'b010, 3'b000, 3'b000, 0, 3'b101, 0, "cc_pulse_load1"));
    cycle(mk(1, 2'd0, 0, 1, 3'b010, 3'b010, 3'b000, 3'b010, 1, 3'b000, 0, "cc_addr1"));
    stall(1, 3'b111, 3'b000, 3'b000, "cc_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
